// File: rtl/uart_pkg.sv
// Shared types and the round-robin pick helper for the UART transmit arbiter.
// Pure declarations: no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} arb_state_t;

    localparam int UART_BYTE_W = 8;
    localparam int RR_MAX      = 8;

    // One-hot of the first set bit of valid at or after ptr, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        ptr,
        input logic [3:0]        n
    );
        logic [RR_MAX-1:0] pick;
        logic [3:0]        pos;
        logic              found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((4'(i) < n) && !found && valid[pos[2:0]]) begin
                pick[pos[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick among N_REQ requesters starting at ptr.
// Zero latency; no backpressure, the pointer register is owned by the caller.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] pick
);

    logic [RR_MAX-1:0] valid_ext;
    logic [RR_MAX-1:0] pick_full;
    logic              unused_pick_hi;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid;
    end

    assign pick_full      = rr_pick(valid_ext, ptr, 4'(N_REQ));
    assign pick           = pick_full[N_REQ-1:0];
    assign unused_pick_hi = |pick_full;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART_TX among N_REQ byte streams, with a done watchdog.
// Grant 1 cycle after valid, start 1 cycle after accept; owner is held (no preemption) until its last byte is done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = UART_BYTE_W,
    parameter int TX_TIMEOUT = 16384
) (
    input  logic                    i_clk,
    input  logic                    i_aresetn,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_done,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int              WD_W    = $clog2(TX_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TX_TIMEOUT);

    arb_state_t        state, state_nxt;
    logic [N_REQ-1:0]  pick;
    logic [2:0]        ptr, ptr_after;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last, last_q;
    logic              load, release_grant, err_nxt;
    logic [WD_W-1:0]   wd;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid (i_req_valid),
        .ptr   (ptr),
        .pick  (pick)
    );

    // Owner's byte, last flag and the pointer slot just past the owner.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        ptr_after = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_grant[k]) begin
                sel_data  = i_req_data[k*DATA_W +: DATA_W];
                sel_last  = i_req_last[k];
                ptr_after = (k == N_REQ - 1) ? 3'd0 : 3'(k + 1);
            end
        end
    end

    assign o_req_ready = (state == LOAD) ? o_grant : '0;
    assign o_busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        release_grant = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (|(i_req_valid & o_req_ready)) begin
                    state_nxt = WAIT_DONE;
                    load      = 1'b1;
                end
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle wins over the abort.
                if (i_tx_done) begin
                    if (last_q) begin
                        state_nxt     = IDLE;
                        release_grant = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end else if (wd == WD_LAST) begin
                    state_nxt     = IDLE;
                    release_grant = 1'b1;
                    err_nxt       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_grant    <= '0;
            ptr        <= '0;
            o_tx_data  <= '0;
            last_q     <= 1'b0;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            wd         <= '0;
        end else begin
            o_tx_start <= load;
            o_err      <= err_nxt;
            if (state == IDLE) begin
                o_grant <= pick;
            end else if (release_grant) begin
                o_grant <= '0;
                ptr     <= ptr_after;
            end
            if (load) begin
                o_tx_data <= sel_data;
                last_q    <= sel_last;
            end
            if ((state == WAIT_DONE) && (state_nxt == WAIT_DONE)) begin
                if (wd != WD_MAX) begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester byte queues, a UART_TX done model with
// compressed frame time, and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int TO       = 64;
    localparam int SUPPRESS = 1000;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [NR-1:0]   req_valid, req_last, req_ready, grant;
    logic [NR*8-1:0] req_data;
    logic            tx_start, tx_done, busy, err;
    logic [7:0]      tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(NR), .DATA_W(8), .TX_TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_aresetn   (aresetn),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_done   (tx_done),
        .o_busy      (busy),
        .o_err       (err)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Per requester: bytes {last, data}; dh = next to offer, eh = next expected on the line.
    logic [8:0]    mem [NR][512];
    int            dh [NR];
    int            eh [NR];
    int            dt [NR];
    int            stall [NR];
    int            m_owner, m_ptr, done_cnt, age, override, nstart, nerr, gn;
    int            gord [512];
    logic          exp_err, cur_last;
    logic [NR-1:0] hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] rr_ref(input logic [NR-1:0] v, input int p);
        logic [NR-1:0] r;
        int            j;
        r = '0;
        for (int i = 0; i < NR; i++) begin
            j = (p + i) % NR;
            if (v[j] && r == '0) r[j] = 1'b1;
        end
        return r;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit drained();
        for (int k = 0; k < NR; k++) if (dh[k] != dt[k] || eh[k] != dt[k]) return 1'b0;
        return (m_owner < 0) && (done_cnt < 0);
    endfunction

    task automatic push_byte(input int k, input logic [7:0] b, input logic l);
        mem[k][dt[k]] = {l, b};
        dt[k]++;
    endtask

    task automatic push(input int k, input int nbytes);
        for (int i = 0; i < nbytes; i++) push_byte(k, 8'($urandom), i == nbytes - 1);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            dh[k]    = dt[k];
            eh[k]    = dt[k];
            stall[k] = 0;
        end
        m_owner   = -1;
        m_ptr     = 0;
        done_cnt  = -1;
        age       = 0;
        override  = -1;
        exp_err   = 1'b0;
        cur_last  = 1'b0;
        hs        = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
    endtask

    // Inputs still hold last cycle's drive here, so req_valid/tx_done are what the DUT just sampled.
    task automatic monitor();
        logic          e_exp, rel_exp, done_prev;
        logic [NR-1:0] oh;
        done_prev = tx_done;
        if (tx_start) age = 0;
        else          age++;
        e_exp = exp_err && (age == TO);
        if (err) nerr++;
        if (err || e_exp) check("err_pulse", err, e_exp);
        if (e_exp) exp_err = 1'b0;

        if (m_owner < 0) begin
            oh = rr_ref(req_valid, m_ptr);
            if (req_valid != '0 || grant != '0) check("grant_pick", grant, oh);
            if (oh != '0) begin
                m_owner   = idx_of(oh);
                gord[gn]  = m_owner;
                gn++;
            end
        end else begin
            oh          = '0;
            oh[m_owner] = 1'b1;
            rel_exp     = (done_prev && cur_last) || e_exp;
            if (rel_exp || grant != oh) check("grant_hold", grant, rel_exp ? '0 : oh);
            if (rel_exp) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end

        if (tx_start || hs != '0) check("start_pulse", tx_start, hs != '0);
        if (tx_start) begin
            nstart++;
            check("busy_on_start", busy, 1);
            check("start_granted", grant != '0, 1);
            if (m_owner >= 0) begin
                check("line_byte", tx_data, mem[m_owner][eh[m_owner]][7:0]);
                cur_last = mem[m_owner][eh[m_owner]][8];
                eh[m_owner]++;
            end
            if (override == SUPPRESS) begin
                done_cnt = -1;
                exp_err  = 1'b1;
            end else begin
                done_cnt = (override >= 0) ? override : int'($urandom_range(1, 62));
                exp_err  = 1'b0;
            end
            override = -1;
        end
        if (req_ready != '0) check("ready_owner", req_ready, grant);
    endtask

    task automatic drive();
        tx_done = (done_cnt == 0);
        if (done_cnt >= 0) done_cnt--;
        for (int k = 0; k < NR; k++) begin
            if (stall[k] > 0) stall[k]--;
            if (dh[k] < dt[k] && stall[k] == 0) begin
                req_valid[k]       = 1'b1;
                req_data[k*8 +: 8] = mem[k][dh[k]][7:0];
                req_last[k]        = mem[k][dh[k]][8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[k*8 +: 8] = 8'($urandom);
                req_last[k]        = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        drive();
        #1;
        hs = req_valid & req_ready;
        for (int k = 0; k < NR; k++) if (hs[k]) dh[k]++;
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (drained()) return;
            step();
        end
        check("drain_budget", drained(), 1);
    endtask

    task automatic wait_start(input int k, input int budget);
        logic [NR-1:0] want;
        want    = '0;
        want[k] = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tx_start && m_owner == k) return;
        end
        check("start_wait_owner", grant, want);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_start"}, tx_start, 0);
        check({tag, "_data"},  tx_data, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        int g0, s0, e0;
        for (int k = 0; k < NR; k++) dt[k] = 0;
        nstart  = 0;
        nerr    = 0;
        gn      = 0;
        model_reset();
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        #2 aresetn = 1'b1;

        // Single packet DE AD BE from requester 0.
        g0 = gn; s0 = nstart;
        push_byte(0, 8'hDE, 1'b0);
        push_byte(0, 8'hAD, 1'b0);
        push_byte(0, 8'hBE, 1'b1);
        step();
        step();
        check("single_grant_latency", grant, 4'b0001);
        run_idle(2000);
        check("single_starts", nstart - s0, 3);
        check("single_owner", gord[g0], 0);

        // Pointer now 1: requester 2 beats 0, then contention between 1 and 3.
        g0 = gn;
        push(0, 1);
        push(2, 1);
        run_idle(2000);
        check("ptr_probe_first", gord[g0], 2);
        check("ptr_probe_second", gord[g0 + 1], 0);
        g0 = gn;
        push(1, 2);
        push(3, 2);
        run_idle(2000);
        check("contend_first", gord[g0], 1);
        check("contend_second", gord[g0 + 1], 3);

        // Fairness: two single-byte packets per requester, all pending together.
        g0 = gn;
        for (int k = 0; k < NR; k++) push(k, 1);
        for (int k = 0; k < NR; k++) push(k, 1);
        run_idle(4000);
        for (int i = 0; i < 2 * NR; i++) check("fair_order", gord[g0 + i], i % NR);

        // Owner stalls mid-packet while others wait.
        g0 = gn;
        push(2, 3);
        wait_start(2, 300);
        push(0, 1);
        push(3, 1);
        stall[2] = 100;
        s0 = nstart;
        for (int i = 0; i < 100; i++) step();
        check("stall_no_start", nstart - s0, 0);
        check("stall_grant_held", grant, 4'b0100);
        run_idle(2000);
        check("stall_after_first", gord[g0 + 1], 3);
        check("stall_after_second", gord[g0 + 2], 0);

        // Serializer never answers: abort, then the next requester is served.
        g0 = gn; e0 = nerr;
        override = SUPPRESS;
        push(1, 2);
        push(2, 1);
        run_idle(2000);
        check("timeout_err_count", nerr - e0, 1);
        check("timeout_victim", gord[g0], 1);
        check("timeout_next", gord[g0 + 1], 2);

        // Done on the last watchdog cycle wins over the abort.
        e0 = nerr;
        override = 63;
        push(0, 1);
        run_idle(2000);
        check("done_wins_no_err", nerr - e0, 0);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 3) == 0) push(k, $urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) stall[k] = $urandom_range(1, 30);
            end
            case ($urandom_range(0, 9))
                0:       override = SUPPRESS;
                1:       override = 63;
                default: ;
            endcase
            repeat ($urandom_range(5, 60)) step();
        end
        run_idle(10000);

        // Async reset while requester 3 is waiting for done; pointer was 3 beforehand.
        push(2, 1);
        run_idle(2000);
        push(3, 2);
        wait_start(3, 300);
        #2 aresetn = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        #2 aresetn = 1'b1;
        g0 = gn;
        push(1, 1);
        push(3, 1);
        run_idle(2000);
        check("post_reset_first", gord[g0], 1);
        check("post_reset_second", gord[g0 + 1], 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
